alu_unit: RTL and testbench

Arithmetic execution unit for the out-of-order core: the receiving end of the reservation station's `ari_*` dispatch interface and the driver of the RS-side result broadcast (`val_flag_RS` / `val_idx_RS` / `val_RS`). It accepts at most one ready instruction per cycle and evaluates it. One cycle later it places the result on the broadcast bus, which the RS, LSB and ROB snoop. Branch outcomes and JALR targets are also returned on this bus for the ROB to resolve.

---
 rtl/alu_unit.sv | 113 +++++++++++
 tb/tb_alu_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - single-stage integer ALU feeding the RS-side result broadcast
// Widths and opcode tags mirror defines.v; guards let defines.v take precedence when present.

`ifndef ILEN
`define ILEN 6
`endif
`ifndef RLEN
`define RLEN 32
`endif
`ifndef RBID
`define RBID 4
`endif

`ifndef NULL6
`define NULL6 6'd0
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define ADDI  6'd19
`define SLTI  6'd20
`define SLTIU 6'd21
`define XORI  6'd22
`define ORI   6'd23
`define ANDI  6'd24
`define SLLI  6'd25
`define SRLI  6'd26
`define SRAI  6'd27
`define ADD   6'd28
`define SUB   6'd29
`define SLL   6'd30
`define SLT   6'd31
`define SLTU  6'd32
`define XOR   6'd33
`define SRL   6'd34
`define SRA   6'd35
`define OR    6'd36
`define AND   6'd37
`endif

module alu_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jp_wrong,
  input  logic              ari_ins_flag,
  input  logic [`ILEN-1:0]  ari_insty,
  input  logic [`RLEN-1:0]  ari_val1,
  input  logic [`RLEN-1:0]  ari_val2,
  input  logic [`RBID-1:0]  ari_ROB_idx,
  output logic              val_flag_RS,
  output logic [`RBID-1:0]  val_idx_RS,
  output logic [`RLEN-1:0]  val_RS
);

  logic [`RLEN-1:0] result;
  logic [4:0]       shamt;
  logic             lt_s;
  logic             lt_u;
  logic [`RLEN-1:0] sum;

  assign shamt = ari_val2[4:0];
  assign lt_s  = $signed(ari_val1) < $signed(ari_val2);
  assign lt_u  = ari_val1 < ari_val2;
  assign sum   = ari_val1 + ari_val2;

  // Unsupported tags still produce a zero broadcast so the ROB entry can retire.
  always_comb begin
    result = '0;
    case (ari_insty)
      `ADD, `ADDI:   result = sum;
      `SUB:          result = ari_val1 - ari_val2;
      `AND, `ANDI:   result = ari_val1 & ari_val2;
      `OR, `ORI:     result = ari_val1 | ari_val2;
      `XOR, `XORI:   result = ari_val1 ^ ari_val2;
      `SLL, `SLLI:   result = ari_val1 << shamt;
      `SRL, `SRLI:   result = ari_val1 >> shamt;
      `SRA, `SRAI:   result = $unsigned($signed(ari_val1) >>> shamt);
      `SLT, `SLTI:   result = {{(`RLEN-1){1'b0}}, lt_s};
      `SLTU, `SLTIU: result = {{(`RLEN-1){1'b0}}, lt_u};
      `BEQ:          result = {{(`RLEN-1){1'b0}}, ari_val1 == ari_val2};
      `BNE:          result = {{(`RLEN-1){1'b0}}, ari_val1 != ari_val2};
      `BLT:          result = {{(`RLEN-1){1'b0}}, lt_s};
      `BGE:          result = {{(`RLEN-1){1'b0}}, ~lt_s};
      `BLTU:         result = {{(`RLEN-1){1'b0}}, lt_u};
      `BGEU:         result = {{(`RLEN-1){1'b0}}, ~lt_u};
      `JALR:         result = {sum[`RLEN-1:1], 1'b0};
      default:       result = '0;
    endcase
  end

  // Broadcast is registered so same-cycle forwarding in consumers never sees a combinational path.
  always_ff @(posedge clk) begin
    if (rst || jp_wrong) begin
      val_flag_RS <= 1'b0;
      val_idx_RS  <= '0;
      val_RS      <= '0;
    end else if (rdy) begin
      val_flag_RS <= ari_ins_flag;
      if (ari_ins_flag) begin
        val_idx_RS <= ari_ROB_idx;
        val_RS     <= result;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit: vector table, hand sequences, random vs model

module tb_alu_unit;

  localparam logic [5:0] T_NULL = 6'd0,  T_LUI  = 6'd1,  T_JALR = 6'd4,
                         T_BEQ  = 6'd5,  T_BNE  = 6'd6,  T_BLT  = 6'd7,
                         T_BGE  = 6'd8,  T_BLTU = 6'd9,  T_BGEU = 6'd10,
                         T_ADDI = 6'd19, T_SLTI = 6'd20, T_SLTIU= 6'd21,
                         T_XORI = 6'd22, T_ORI  = 6'd23, T_ANDI = 6'd24,
                         T_SLLI = 6'd25, T_SRLI = 6'd26, T_SRAI = 6'd27,
                         T_ADD  = 6'd28, T_SUB  = 6'd29, T_SLL  = 6'd30,
                         T_SLT  = 6'd31, T_SLTU = 6'd32, T_XOR  = 6'd33,
                         T_SRL  = 6'd34, T_SRA  = 6'd35, T_OR   = 6'd36,
                         T_AND  = 6'd37;

  logic        clk = 1'b0;
  logic        rst, rdy, jp_wrong, ari_ins_flag;
  logic [5:0]  ari_insty;
  logic [31:0] ari_val1, ari_val2;
  logic [3:0]  ari_ROB_idx;
  logic        val_flag_RS;
  logic [3:0]  val_idx_RS;
  logic [31:0] val_RS;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .ari_ins_flag(ari_ins_flag), .ari_insty(ari_insty),
    .ari_val1(ari_val1), .ari_val2(ari_val2), .ari_ROB_idx(ari_ROB_idx),
    .val_flag_RS(val_flag_RS), .val_idx_RS(val_idx_RS), .val_RS(val_RS)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic flag, input logic [5:0] tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] idx);
    ari_ins_flag = flag;
    ari_insty    = tag;
    ari_val1     = a;
    ari_val2     = b;
    ari_ROB_idx  = idx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: results from the ISA definitions using integer arithmetic and 64-bit widening.
  function automatic logic [31:0] ref_alu(input logic [5:0] tag, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb;
    longint      ext;
    int unsigned sh;
    sa  = int'(a);
    sb  = int'(b);
    sh  = b % 32;
    ext = longint'(sa);
    case (tag)
      T_ADD, T_ADDI:   return 32'(longint'(a) + longint'(b));
      T_SUB:           return 32'(longint'(a) - longint'(b));
      T_AND, T_ANDI:   return a & b;
      T_OR, T_ORI:     return a | b;
      T_XOR, T_XORI:   return a ^ b;
      T_SLL, T_SLLI:   return 32'(longint'(a) * (longint'(1) << sh));
      T_SRL, T_SRLI:   return a / (32'd1 << sh);
      T_SRA, T_SRAI:   return 32'(ext >>> sh);
      T_SLT, T_SLTI:   return (sa < sb) ? 32'd1 : 32'd0;
      T_SLTU, T_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      T_BEQ:           return (a == b) ? 32'd1 : 32'd0;
      T_BNE:           return (a != b) ? 32'd1 : 32'd0;
      T_BLT:           return (sa < sb) ? 32'd1 : 32'd0;
      T_BGE:           return (sa >= sb) ? 32'd1 : 32'd0;
      T_BLTU:          return (a < b) ? 32'd1 : 32'd0;
      T_BGEU:          return (a >= b) ? 32'd1 : 32'd0;
      T_JALR:          return 32'((longint'(a) + longint'(b)) / 2 * 2);
      default:         return 32'd0;
    endcase
  endfunction

  initial begin
    logic        m_flag;
    logic [3:0]  m_idx;
    logic [31:0] m_val;
    logic        check_data;

    vecs[0]  = '{T_ADD,  32'hFFFFFFFF, 32'h00000001, 4'd3,  32'h00000000};
    vecs[1]  = '{T_SUB,  32'h00000000, 32'h00000001, 4'd4,  32'hFFFFFFFF};
    vecs[2]  = '{T_SRA,  32'h80000000, 32'h00000021, 4'd5,  32'hC0000000};
    vecs[3]  = '{T_SLT,  32'hFFFFFFFF, 32'h00000001, 4'd6,  32'h00000001};
    vecs[4]  = '{T_SLTU, 32'hFFFFFFFF, 32'h00000001, 4'd7,  32'h00000000};
    vecs[5]  = '{T_BGE,  32'hFFFFFFFB, 32'hFFFFFFFB, 4'd8,  32'h00000001};
    vecs[6]  = '{T_BLTU, 32'h00000001, 32'hFFFFFFFF, 4'd9,  32'h00000001};
    vecs[7]  = '{T_BNE,  32'h00000007, 32'h00000007, 4'd10, 32'h00000000};
    vecs[8]  = '{T_JALR, 32'h00001001, 32'h00000004, 4'd11, 32'h00001004};
    vecs[9]  = '{T_SLLI, 32'h00000001, 32'h0000003F, 4'd12, 32'h80000000};
    vecs[10] = '{T_SRL,  32'h80000000, 32'h00000024, 4'd13, 32'h08000000};
    vecs[11] = '{T_XORI, 32'hF0F0F0F0, 32'hFF00FF00, 4'd14, 32'h0FF00FF0};
    vecs[12] = '{T_LUI,  32'h12345678, 32'h00000009, 4'd15, 32'h00000000};
    vecs[13] = '{T_BLT,  32'hFFFFFFFF, 32'h00000000, 4'd0,  32'h00000001};
    vecs[14] = '{T_BEQ,  32'h00000005, 32'h00000005, 4'd1,  32'h00000001};
    vecs[15] = '{T_SLTI, 32'h00000001, 32'hFFFFFFFF, 4'd2,  32'h00000000};
    vecs[16] = '{T_BGEU, 32'h00000000, 32'h00000001, 4'd3,  32'h00000000};
    vecs[17] = '{T_ORI,  32'h0000000F, 32'h000000F0, 4'd4,  32'h000000FF};
    vecs[18] = '{T_AND,  32'h0000FF00, 32'h00000FF0, 4'd5,  32'h00000F00};

    rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0;
    drive(1'b1, T_ADD, 32'h11, 32'h22, 4'd9);

    // Reset held two cycles with a dispatch present: outputs stay zero.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_flag", 32'(val_flag_RS), 32'd0);
      chk("reset_idx",  32'(val_idx_RS),  32'd0);
      chk("reset_val",  val_RS,           32'd0);
    end
    rst = 1'b0;

    // Directed vectors dispatched back-to-back.
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].idx);
      step();
      chk($sformatf("vec%0d_flag", i), 32'(val_flag_RS), 32'd1);
      chk($sformatf("vec%0d_idx", i),  32'(val_idx_RS),  32'(vecs[i].idx));
      chk($sformatf("vec%0d_val", i),  val_RS,           vecs[i].exp);
    end
    drive(1'b0, T_NULL, 32'd0, 32'd0, 4'd0);
    step();
    chk("idle_flag", 32'(val_flag_RS), 32'd0);

    // Pipeline with a two-cycle stall after the second dispatch.
    drive(1'b1, T_ADD, 32'd10, 32'd20, 4'd1);
    step();
    chk("pipe1_flag", 32'(val_flag_RS), 32'd1);
    chk("pipe1_idx",  32'(val_idx_RS),  32'd1);
    chk("pipe1_val",  val_RS,           32'd30);
    drive(1'b1, T_XOR, 32'hFF, 32'h0F, 4'd2);
    step();
    chk("pipe2_idx",  32'(val_idx_RS),  32'd2);
    chk("pipe2_val",  val_RS,           32'hF0);
    rdy = 1'b0;
    drive(1'b1, T_AND, 32'hFF, 32'h3C, 4'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_flag", 32'(val_flag_RS), 32'd1);
      chk("stall_idx",  32'(val_idx_RS),  32'd2);
      chk("stall_val",  val_RS,           32'hF0);
    end
    rdy = 1'b1;
    step();
    chk("pipe3_flag", 32'(val_flag_RS), 32'd1);
    chk("pipe3_idx",  32'(val_idx_RS),  32'd3);
    chk("pipe3_val",  val_RS,           32'h3C);
    drive(1'b0, T_NULL, 32'd0, 32'd0, 4'd0);
    step();
    chk("pipe_end_flag", 32'(val_flag_RS), 32'd0);

    // Flush discards the same-cycle dispatch; the next one broadcasts normally.
    jp_wrong = 1'b1;
    drive(1'b1, T_ORI, 32'h1, 32'h2, 4'd5);
    step();
    chk("flush_flag", 32'(val_flag_RS), 32'd0);
    chk("flush_idx",  32'(val_idx_RS),  32'd0);
    jp_wrong = 1'b0;
    drive(1'b1, T_ADDI, 32'd100, 32'hFFFFFFFF, 4'd6);
    step();
    chk("post_flush_flag", 32'(val_flag_RS), 32'd1);
    chk("post_flush_idx",  32'(val_idx_RS),  32'd6);
    chk("post_flush_val",  val_RS,           32'd99);

    // Reset wins over a stalled rdy.
    rst = 1'b1; rdy = 1'b0;
    step();
    chk("rst_over_rdy_flag", 32'(val_flag_RS), 32'd0);
    chk("rst_over_rdy_val",  val_RS,           32'd0);
    rst = 1'b0; rdy = 1'b1;
    m_flag = 1'b0; m_idx = '0; m_val = '0;

    // Randomised traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic r_rst, r_jp, r_rdy, r_flag;
      logic [5:0]  r_tag;
      logic [31:0] r_a, r_b;
      logic [3:0]  r_idx;
      r_rst  = ($urandom_range(49, 0) == 0);
      r_jp   = ($urandom_range(19, 0) == 0);
      r_rdy  = ($urandom_range(3, 0) != 0);
      r_flag = ($urandom_range(3, 0) != 0);
      r_tag  = 6'($urandom_range(40, 0));
      r_a    = ($urandom_range(3, 0) == 0) ? 32'h80000000 : $urandom;
      r_b    = ($urandom_range(3, 0) == 0) ? r_a : $urandom;
      r_idx  = 4'($urandom_range(15, 0));
      rst = r_rst; jp_wrong = r_jp; rdy = r_rdy;
      drive(r_flag, r_tag, r_a, r_b, r_idx);
      check_data = 1'b0;
      if (r_rst || r_jp) begin
        m_flag = 1'b0; m_idx = '0; m_val = '0;
        check_data = 1'b1;
      end else if (r_rdy) begin
        m_flag = r_flag;
        if (r_flag) begin
          m_idx = r_idx;
          m_val = ref_alu(r_tag, r_a, r_b);
        end
      end
      if (m_flag) check_data = 1'b1;
      step();
      chk("rand_flag", 32'(val_flag_RS), 32'(m_flag));
      if (check_data) begin
        chk("rand_idx", 32'(val_idx_RS), 32'(m_idx));
        chk("rand_val", val_RS,          m_val);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
